sent_tx_pulse_gen: RTL and testbench
====================================

// Module: sent_tx_pulse_gen
// PURPOSE
//  SENT (SAE J2716) fast-channel transmitter: the transmit end of the single-wire pulse link
//  that sent_rx decodes. Each accepted request becomes one frame on data_pulse:
//  sync, status nibble, 6 data nibbles, CRC nibble, and an optional pause pulse.
//  Sits between the serial-message/status builder and the output pad driver.
// PARAMETERS
//  TICK_DIV    6    clk_tx cycles per SENT tick (>=2)
//  LOW_TICKS   5    low-phase length of every symbol, in ticks (<12)
//  PAUSE_EN    0    1 = append pause pulse for constant frame length
//  FRAME_TICKS 282  total frame length in ticks when PAUSE_EN=1 (>=257)
// PORTS
//  clk_tx      in   1   transmit clock
//  reset_n_tx  in   1   async active-low reset
//  tx_valid    in   1   frame request
//  tx_ready    out  1   request accepted when tx_valid&&tx_ready
//  status_nb   in   4   status/communication nibble (bits 3:2 carry slow-channel bits)
//  frame_data  in   24  6 data nibbles, [23:20] transmitted first
//  data_pulse  out  1   SENT line, idle high
//  busy        out  1   frame in progress
//  frame_done  out  1   1-cycle pulse, last symbol of frame complete
// BEHAVIOUR
//  Reset (async, active low): state IDLE, data_pulse=1, busy=0, frame_done=0, tick/symbol counters=0.
//   Asserted mid-frame: line goes high immediately; the partial frame is abandoned and not resumed.
//  FSM: IDLE -> SYNC -> STATUS -> DATA(x6) -> CRC -> [PAUSE if PAUSE_EN] -> IDLE or SYNC.
//  Accept: status_nb, frame_data and the CRC are latched; the tick prescaler clears.
//   data_pulse falls on the first clk edge after accept (1-cycle latency).
//  Symbol: falling edge at start; low for LOW_TICKS ticks, then high for the rest of the symbol.
//   Durations in ticks:
//    sync = 56
//    nibble value v = 12+v (12..27)
//    pause = FRAME_TICKS - (56 + status + data + CRC ticks)
//  CRC: 4-bit, seed 4'h5, poly x^4+x^3+x^2+1, computed over the 6 data nibbles only (status excluded).
//   Per data bit b, MSB first: fb=crc[3]; crc={crc[2:0],b}; if fb, crc^=4'hD.
//   After the data, 4 augmentation zero bits are shifted the same way.
//   Computed combinationally from the inputs and registered at accept.
//  tx_ready: high in IDLE, and combinationally high in the final clk of the last symbol.
//   An accept in that cycle starts the next sync falling edge with no gap.
//   Otherwise the line stays high in IDLE.
//  tx_valid while busy and not in the final clk: ignored; inputs are not re-sampled.
//  frame_done: asserted in the final clk of the last symbol (CRC, or PAUSE when PAUSE_EN=1).
//  busy: 1 from the clk after accept until the clk after frame_done without a new accept.
//  Counters must not wrap: the symbol tick counter is >=8 bits wide, sized for FRAME_TICKS.
// TESTING
//  T1 reset: hold reset_n_tx=0 -> data_pulse=1, tx_ready=1, busy=0, frame_done=0.
//  T2 status=0, data=24'h000000, PAUSE_EN=0:
//     falling-edge spacing 56,12,12,12,12,12,12,12,17 ticks (CRC=4'h5).
//     Each low phase = 30 clk; frame_done 942 clk after the first fall.
//  T3 status=4'hF, data=24'hFFFFFF:
//     status/data spacing 27 ticks each; CRC nibble width = 12 + golden-model CRC.
//  T4 PAUSE_EN=1, FRAME_TICKS=282, data as T2 -> pause symbol = 125 ticks.
//     Sync-to-sync period = 282 ticks = 1692 clk.
//  T5 tx_valid held high, two frames -> second sync falls exactly at the end of the first
//     frame's last symbol; second frame carries the second data set.
//  T6 reset_n_tx low during the 3rd data nibble -> data_pulse=1 asynchronously.
//     After release: no pulses until the next accept.

Source files
------------

// File: rtl/sent_tx_pulse_gen.sv
// SENT fast-channel transmitter: turns each accepted request into one SENT frame on data_pulse.
// State | meaning: IDLE waiting for request | SYNC 56-tick sync | STATUS status nibble | DATA 6 data nibbles | CRC crc nibble | PAUSE optional pause pulse
module sent_tx_pulse_gen #(
  parameter int TICK_DIV    = 6,
  parameter int LOW_TICKS   = 5,
  parameter int PAUSE_EN    = 0,
  parameter int FRAME_TICKS = 282
) (
  input  logic        clk_tx,
  input  logic        reset_n_tx,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [3:0]  status_nb,
  input  logic [23:0] frame_data,
  output logic        data_pulse,
  output logic        busy,
  output logic        frame_done
);

  localparam int TW = ($clog2(FRAME_TICKS + 1) > 9) ? $clog2(FRAME_TICKS + 1) : 9;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LOAD = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] FRAME_T    = TW'(FRAME_TICKS);
  localparam logic [TW-1:0] LOW_T      = TW'(LOW_TICKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_STATUS,
    S_DATA,
    S_CRC,
    S_PAUSE
  } state_t;

  function automatic logic [TW-1:0] ext4(input logic [3:0] n);
    return {{(TW-4){1'b0}}, n};
  endfunction

  function automatic logic [3:0] nib_sel(input logic [23:0] d, input logic [2:0] idx);
    logic [3:0] n;
    case (idx)
      3'd0:    n = d[23:20];
      3'd1:    n = d[19:16];
      3'd2:    n = d[15:12];
      3'd3:    n = d[11:8];
      3'd4:    n = d[7:4];
      3'd5:    n = d[3:0];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // Data bits MSB first, then four zero bits of augmentation.
  function automatic logic [3:0] crc4(input logic [23:0] d);
    logic [27:0] m;
    logic [3:0]  c;
    logic        fb;
    m = {d, 4'h0};
    c = 4'h5;
    for (int i = 27; i >= 0; i--) begin
      fb = c[3];
      c  = {c[2:0], m[i]};
      if (fb) c = c ^ 4'hD;
    end
    return c;
  endfunction

  function automatic logic [TW-1:0] sym_len(input state_t s, input logic [2:0] idx,
                                            input logic [3:0] st, input logic [23:0] d,
                                            input logic [3:0] crc, input logic [TW-1:0] pause);
    logic [TW-1:0] len;
    case (s)
      S_SYNC:   len = TW'(56);
      S_STATUS: len = TW'(12) + ext4(st);
      S_DATA:   len = TW'(12) + ext4(nib_sel(d, idx));
      S_CRC:    len = TW'(12) + ext4(crc);
      S_PAUSE:  len = pause;
      default:  len = TW'(1);
    endcase
    return len;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_nib_idx, w_nib_idx_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [TW-1:0] r_tick_rem, w_tick_rem_nxt;
  logic [3:0]    r_status;
  logic [23:0]   r_data;
  logic [3:0]    r_crc;
  logic [TW-1:0] r_pause_len;
  logic          r_data_pulse;

  logic [3:0]    w_crc;
  logic [TW-1:0] w_used;
  logic [TW-1:0] w_pause_len;
  logic [TW-1:0] w_len_nxt;
  logic          w_tick;
  logic          w_sym_end;
  logic          w_last_sym;
  logic          w_load;
  logic          w_pulse_nxt;

  always_comb begin
    w_crc  = crc4(frame_data);
    w_used = TW'(152) + ext4(status_nb) + ext4(w_crc);
    for (int i = 0; i < 6; i++) w_used = w_used + ext4(frame_data[4*i +: 4]);
    // Degenerate configurations still get a pause longer than its low phase.
    if (FRAME_T > w_used + LOW_T) w_pause_len = FRAME_T - w_used;
    else                          w_pause_len = LOW_T + TW'(1);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_nib_idx_nxt  = r_nib_idx;
    w_presc_nxt    = r_presc;
    w_tick_rem_nxt = r_tick_rem;
    tx_ready       = 1'b0;
    frame_done     = 1'b0;
    w_tick         = (r_presc == '0);
    w_sym_end      = (r_state != S_IDLE) && w_tick && (r_tick_rem == '0);
    w_last_sym     = (r_state == ((PAUSE_EN != 0) ? S_PAUSE : S_CRC));

    case (r_state)
      S_IDLE: tx_ready = 1'b1;
      default: begin
        if (w_sym_end) begin
          case (r_state)
            S_SYNC: w_state_nxt = S_STATUS;
            S_STATUS: begin
              w_state_nxt   = S_DATA;
              w_nib_idx_nxt = '0;
            end
            S_DATA:
              if (r_nib_idx == 3'd5) w_state_nxt = S_CRC;
              else                   w_nib_idx_nxt = r_nib_idx + 3'd1;
            S_CRC:   w_state_nxt = (PAUSE_EN != 0) ? S_PAUSE : S_IDLE;
            default: w_state_nxt = S_IDLE;
          endcase
          if (w_last_sym) begin
            tx_ready   = 1'b1;
            frame_done = 1'b1;
          end
        end else if (w_tick) begin
          w_presc_nxt    = PRESC_LOAD;
          w_tick_rem_nxt = r_tick_rem - TW'(1);
        end else begin
          w_presc_nxt = r_presc - PW'(1);
        end
      end
    endcase

    w_load = tx_ready && tx_valid;
    if (w_load) begin
      w_state_nxt   = S_SYNC;
      w_nib_idx_nxt = '0;
    end

    // Sync length is fixed, so the next symbol length never needs the not-yet-latched inputs.
    w_len_nxt = sym_len(w_state_nxt, w_nib_idx_nxt, r_status, r_data, r_crc, r_pause_len);
    if (w_sym_end || w_load) begin
      w_presc_nxt    = PRESC_LOAD;
      w_tick_rem_nxt = w_len_nxt - TW'(1);
    end

    w_pulse_nxt = (w_state_nxt == S_IDLE) ||
                  (({1'b0, w_tick_rem_nxt} + {1'b0, LOW_T}) < {1'b0, w_len_nxt});
  end

  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      r_state      <= S_IDLE;
      r_nib_idx    <= '0;
      r_presc      <= '0;
      r_tick_rem   <= '0;
      r_status     <= '0;
      r_data       <= '0;
      r_crc        <= '0;
      r_pause_len  <= '0;
      r_data_pulse <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_nib_idx    <= w_nib_idx_nxt;
      r_presc      <= w_presc_nxt;
      r_tick_rem   <= w_tick_rem_nxt;
      r_data_pulse <= w_pulse_nxt;
      if (w_load) begin
        r_status    <= status_nb;
        r_data      <= frame_data;
        r_crc       <= w_crc;
        r_pause_len <= w_pause_len;
      end
    end
  end

  assign data_pulse = r_data_pulse;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
// Bench for sent_tx_pulse_gen: two instances (no pause / with pause) checked against a
// frame-level model that predicts every line edge and frame_done from the symbol tick lengths.
module tb_sent_tx_pulse_gen;

  localparam int TD  = 6;
  localparam int LOW = 5;
  localparam int FT  = 282;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  vld;
  logic [3:0]  sts [2];
  logic [23:0] din [2];
  logic [1:0]  rdy, pulse, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_q[$];
  int obs_q[$];
  int sym_start[10];
  logic [1:0] prev = 2'b11;

  sent_tx_pulse_gen #(.TICK_DIV(TD), .LOW_TICKS(LOW), .PAUSE_EN(0), .FRAME_TICKS(FT)) dut0 (
    .clk_tx(clk), .reset_n_tx(rst_n), .tx_valid(vld[0]), .tx_ready(rdy[0]),
    .status_nb(sts[0]), .frame_data(din[0]), .data_pulse(pulse[0]), .busy(busy[0]),
    .frame_done(done[0]));

  sent_tx_pulse_gen #(.TICK_DIV(TD), .LOW_TICKS(LOW), .PAUSE_EN(1), .FRAME_TICKS(FT)) dut1 (
    .clk_tx(clk), .reset_n_tx(rst_n), .tx_valid(vld[1]), .tx_ready(rdy[1]),
    .status_nb(sts[1]), .frame_data(din[1]), .data_pulse(pulse[1]), .busy(busy[1]),
    .frame_done(done[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event code: instance*1e7 + kind*1e6 + cycle, kind 0 = fall, 1 = rise, 2 = frame_done.
  function automatic int ev(input int d, input int k, input int c);
    return d * 10000000 + k * 1000000 + c;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n) begin
        if (prev[d] && !pulse[d]) obs_q.push_back(ev(d, 0, cyc));
        if (!prev[d] && pulse[d]) obs_q.push_back(ev(d, 1, cyc));
        if (done[d])              obs_q.push_back(ev(d, 2, cyc));
      end
    end
    prev <= pulse;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Polynomial remainder of {seed, data, 0000} modulo x^4+x^3+x^2+1.
  function automatic int crc_model(input logic [23:0] dat);
    logic [31:0] v;
    v = {4'h5, dat, 4'h0};
    for (int i = 31; i >= 4; i--)
      if (v[i]) v = v ^ (32'h1D << (i - 4));
    return int'(v[3:0]);
  endfunction

  task automatic paint(input int d, input int a, input logic [3:0] st, input logic [23:0] dat,
                       output int fin);
    int len[10];
    int n, t, used;
    len[0] = 56;
    len[1] = 12 + int'(st);
    for (int i = 0; i < 6; i++) len[2 + i] = 12 + int'((dat >> (20 - 4 * i)) & 24'hF);
    len[8] = 12 + crc_model(dat);
    used = 0;
    for (int i = 0; i < 9; i++) used += len[i];
    n = 9;
    if (d == 1) begin
      len[9] = FT - used;
      n = 10;
    end
    t = a;
    for (int k = 0; k < n; k++) begin
      sym_start[k] = t;
      exp_q.push_back(ev(d, 0, t));
      exp_q.push_back(ev(d, 1, t + LOW * TD));
      t += len[k] * TD;
    end
    exp_q.push_back(ev(d, 2, t - 1));
    fin = t;
  endtask

  task automatic check_events();
    int e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      check_eq("edge_event", o, e);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check_eq("extra_event", o, -1);
    end
  endtask

  task automatic prune(input int upto);
    while (exp_q.size() > 0 && (exp_q[exp_q.size() - 1] % 1000000) > upto) void'(exp_q.pop_back());
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic send(input int d, input logic [3:0] st, input logic [23:0] dat, input int gap);
    int a, fin;
    repeat (gap + 1) @(negedge clk);
    check_eq("idle_busy", 32'(busy[d]), 0);
    check_eq("idle_ready", 32'(rdy[d]), 1);
    vld[d] = 1'b1;
    sts[d] = st;
    din[d] = dat;
    a = cyc + 1;
    paint(d, a, st, dat, fin);
    @(negedge clk);
    vld[d] = 1'b0;
    sts[d] = 4'($urandom());
    din[d] = 24'($urandom());
    check_eq("accept_busy", 32'(busy[d]), 1);
    wait_to(fin - 1);
    check_eq("last_ready", 32'(rdy[d]), 1);
    check_eq("last_busy", 32'(busy[d]), 1);
    @(negedge clk);
    check_eq("end_busy", 32'(busy[d]), 0);
    check_eq("end_line", 32'(pulse[d]), 1);
    #1 check_events();
  endtask

  task automatic b2b(input int d);
    int a1, f1, f2;
    logic [3:0]  s2;
    logic [23:0] d2;
    s2 = 4'($urandom());
    d2 = 24'($urandom());
    @(negedge clk);
    check_eq("b2b_ready_idle", 32'(rdy[d]), 1);
    vld[d] = 1'b1;
    sts[d] = 4'($urandom());
    din[d] = 24'($urandom());
    a1 = cyc + 1;
    paint(d, a1, sts[d], din[d], f1);
    @(negedge clk);
    sts[d] = s2;
    din[d] = d2;
    check_eq("b2b_ready_busy", 32'(rdy[d]), 0);
    check_eq("b2b_busy", 32'(busy[d]), 1);
    wait_to(f1 - 1);
    check_eq("b2b_ready_last", 32'(rdy[d]), 1);
    paint(d, f1, s2, d2, f2);
    @(negedge clk);
    vld[d] = 1'b0;
    check_eq("b2b_busy_second", 32'(busy[d]), 1);
    wait_to(f2 - 1);
    check_eq("b2b_ready_last2", 32'(rdy[d]), 1);
    @(negedge clk);
    check_eq("b2b_end_busy", 32'(busy[d]), 0);
    #1 check_events();
  endtask

  task automatic reset_mid();
    int a, fin;
    @(negedge clk);
    vld[0] = 1'b1;
    sts[0] = 4'($urandom());
    din[0] = 24'($urandom());
    a = cyc + 1;
    paint(0, a, sts[0], din[0], fin);
    @(negedge clk);
    vld[0] = 1'b0;
    wait_to(sym_start[4] + LOW);
    check_eq("rst_mid_low", 32'(pulse[0]), 0);
    #1;
    prune(cyc);
    check_events();
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_line", 32'(pulse[0]), 1);
    check_eq("rst_async_busy", 32'(busy[0]), 0);
    check_eq("rst_async_ready", 32'(rdy[0]), 1);
    check_eq("rst_async_done", 32'(done[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    check_eq("post_rst_line", 32'(pulse[0]), 1);
    check_eq("post_rst_busy", 32'(busy[0]), 0);
    #1 check_events();
  endtask

  initial begin
    vld    = 2'b00;
    sts[0] = 4'h0;
    sts[1] = 4'h0;
    din[0] = 24'h0;
    din[1] = 24'h0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("reset_line", 32'(pulse[d]), 1);
      check_eq("reset_ready", 32'(rdy[d]), 1);
      check_eq("reset_busy", 32'(busy[d]), 0);
      check_eq("reset_done", 32'(done[d]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 4'h0, 24'h000000, 0);
    send(0, 4'hF, 24'hFFFFFF, 3);
    for (int i = 0; i < 4; i++)
      send(0, 4'($urandom()), 24'($urandom()), int'($urandom_range(0, 20)));
    b2b(0);

    send(1, 4'h0, 24'h000000, 0);
    send(1, 4'($urandom()), 24'($urandom()), int'($urandom_range(0, 20)));
    b2b(1);

    reset_mid();
    send(0, 4'($urandom()), 24'($urandom()), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
